// File: rtl/sequenciador_execucao.sv
// rtl/sequenciador_execucao.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
`timescale 1ns/1ps
module sequenciador_execucao #(
  parameter int MAX_ESPERA = 15,
  parameter int LARG_CONT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic [6:0]           opcode,
  input  logic                 regWrite_uc,
  input  logic                 MemWrite_uc,
  input  logic                 mem_pronto,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [2:0]           estado,
  output logic                 parado,
  output logic                 ilegal,
  output logic [LARG_CONT-1:0] instr_count
);

  typedef enum logic [2:0] {
    PARADO = 3'd0,
    BUSCA  = 3'd1,
    DECOD  = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    ESCR   = 3'd5,
    ERRO   = 3'd6
  } estado_t;

  estado_t    est;
  logic       step_q;
  logic [7:0] espera;
  logic       step_borda;
  logic       op_legal;
  logic       op_load;
  logic       op_store;

  assign step_borda = step & ~step_q;
  assign op_load    = (opcode == 7'b0000011);
  assign op_store   = (opcode == 7'b0100011);

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      est         <= PARADO;
      step_q      <= 1'b0;
      espera      <= 8'd0;
      instr_count <= '0;
    end else begin
      step_q <= step;
      case (est)
        PARADO: if (step_borda || (run && !halt_req)) est <= BUSCA;
        BUSCA:  est <= DECOD;
        DECOD:  est <= op_legal ? EXEC : ERRO;
        EXEC: begin
          espera <= 8'd0;
          est    <= (op_load || op_store) ? MEM : ESCR;
        end
        MEM: begin
          // espera counts low cycles already seen; the MAX_ESPERA-th low cycle traps
          if (!op_load || mem_pronto) begin
            est <= ESCR;
          end else begin
            espera <= espera + 8'd1;
            if (espera == 8'(MAX_ESPERA - 1)) est <= ERRO;
          end
        end
        ESCR: begin
          instr_count <= instr_count + LARG_CONT'(1);
          est         <= (halt_req || !run) ? PARADO : BUSCA;
        end
        ERRO:    est <= ERRO;
        default: est <= PARADO;
      endcase
    end
  end

  assign estado = est;
  assign parado = (est == PARADO);
  assign ilegal = (est == ERRO);
  assign ir_we  = (est == BUSCA);
  assign pc_we  = (est == ESCR);
  assign reg_we = (est == ESCR) && regWrite_uc;
  assign mem_we = (est == MEM) && op_store && MemWrite_uc;
  assign mem_re = (est == MEM) && op_load;

endmodule

// File: tb/tb_sequenciador_execucao.sv
// tb/tb_sequenciador_execucao.sv - scoreboard bench for sequenciador_execucao
`timescale 1ns/1ps
module tb_sequenciador_execucao;
  localparam int MAXE = 15;
  localparam int LC   = 16;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic regWrite_uc = 1'b0, MemWrite_uc = 1'b0, mem_pronto = 1'b0;
  logic ir_we, pc_we, reg_we, mem_we, mem_re, parado, ilegal;
  logic [2:0] estado;
  logic [LC-1:0] instr_count;

  sequenciador_execucao #(.MAX_ESPERA(MAXE), .LARG_CONT(LC)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .opcode(opcode), .regWrite_uc(regWrite_uc), .MemWrite_uc(MemWrite_uc),
    .mem_pronto(mem_pronto), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .mem_we(mem_we), .mem_re(mem_re), .estado(estado), .parado(parado),
    .ilegal(ilegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    bit trap;
    int lat;
    int n_reg;
    int n_memw;
    int n_memr;
    int cnt;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;
  int   k_low = 0;
  int   mem_cyc = 0;
  int   model_cnt = 0;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
  endfunction

  // Reference: what one instruction should cost and do, from the opcode class alone
  function automatic exp_t model(input logic [6:0] op, input bit rw, input bit mw,
                                 input int k, input int cnt);
    exp_t e;
    e = '{default: 0};
    e.cnt = cnt;
    if (!is_legal(op)) begin
      e.trap = 1'b1;
    end else if (op == OP_LOAD) begin
      if (k >= MAXE) begin
        e.trap = 1'b1;
        e.n_memr = MAXE;
      end else begin
        e.lat = 5 + k;
        e.n_memr = k + 1;
        e.n_reg = int'(rw);
      end
    end else if (op == OP_STORE) begin
      e.lat = 5;
      e.n_reg = int'(rw);
      e.n_memw = int'(mw);
    end else begin
      e.lat = 4;
      e.n_reg = int'(rw);
    end
    return e;
  endfunction

  // Data memory: k_low not-ready cycles per load, random noise otherwise
  always @(negedge clk) begin
    if (mem_re) begin
      mem_cyc = mem_cyc + 1;
      mem_pronto = (mem_cyc > k_low);
    end else begin
      mem_cyc = 0;
      mem_pronto = 1'($urandom_range(0, 1));
    end
  end

  int  m_lat, m_reg, m_memw, m_memr;
  bit  m_active = 1'b0;
  exp_t m_e;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (ir_we) begin
        m_active = 1'b1;
        m_lat = 1; m_reg = 0; m_memw = 0; m_memr = 0;
      end else if (m_active) begin
        m_lat++;
      end
      if (m_active) begin
        m_reg  += int'(reg_we);
        m_memw += int'(mem_we);
        m_memr += int'(mem_re);
        if (pc_we || ilegal) begin
          if (q.size() == 0) begin
            check("queue_underflow", 0, 1);
          end else begin
            m_e = q.pop_front();
            check("trap_flag", int'(ilegal), int'(m_e.trap));
            check("reg_we_pulses", m_reg, m_e.n_reg);
            check("mem_we_pulses", m_memw, m_e.n_memw);
            check("mem_re_cycles", m_memr, m_e.n_memr);
            if (pc_we) begin
              check("latency", m_lat, m_e.lat);
              check("instr_count_at_escr", int'(instr_count), m_e.cnt);
            end
          end
          m_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int seq[4];
    int hold, c;
    bit rw, mw, done;
    logic [6:0] op;
    logic [6:0] legal_ops[8];
    exp_t e;
    seq = '{1, 2, 3, 5};
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    #2;
    check("reset_estado", int'(estado), 0);
    check("reset_parado", int'(parado), 1);
    check("reset_enables", int'({ir_we, pc_we, reg_we, mem_we, mem_re}), 0);
    check("reset_ilegal", int'(ilegal), 0);
    check("reset_count", int'(instr_count), 0);

    // Free-running R-type stream
    run = 1'b1; opcode = OP_R; regWrite_uc = 1'b1;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      check("run_estado", int'(estado), seq[i % 4]);
      check("run_pc_we", int'(pc_we), int'(i % 4 == 3));
    end
    check("run_count_after_12", int'(instr_count), 3);

    // Store with halt_req raised during EXEC
    @(negedge clk); reset = 1'b0;
    opcode = OP_STORE; MemWrite_uc = 1'b1; regWrite_uc = 1'b0;
    @(negedge clk); reset = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (estado == 3'd3) done = 1'b1;
    end
    check("store_reach_exec", int'(done), 1);
    halt_req = 1'b1;
    @(posedge clk); #1;
    check("store_mem_estado", int'(estado), 4);
    check("store_mem_we", int'(mem_we), 1);
    @(posedge clk); #1;
    check("store_escr_estado", int'(estado), 5);
    check("store_mem_we_once", int'(mem_we), 0);
    check("store_pc_we", int'(pc_we), 1);
    @(posedge clk); #1;
    check("halt_parado", int'(parado), 1);
    check("halt_count", int'(instr_count), 1);
    repeat (3) @(posedge clk);
    #1;
    check("halt_stays_parado", int'(estado), 0);

    // Reset in the middle of an instruction
    @(negedge clk); halt_req = 1'b0; opcode = OP_R; regWrite_uc = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (estado == 3'd3) done = 1'b1;
    end
    check("midreset_reach_exec", int'(done), 1);
    reset = 1'b0;
    #1;
    check("midreset_estado", int'(estado), 0);
    check("midreset_pc_we", int'(pc_we), 0);
    check("midreset_reg_we", int'(reg_we), 0);
    check("midreset_count", int'(instr_count), 0);
    run = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Randomised single-step stream checked by the scoreboard
    mon_en = 1'b1;
    model_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 7'($urandom_range(0, 127));
        while (is_legal(op)) op = 7'($urandom_range(0, 127));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      rw = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 20);
      @(negedge clk);
      opcode = op; regWrite_uc = rw; MemWrite_uc = mw;
      k_low = $urandom_range(0, 17);
      e = model(op, rw, mw, k_low, model_cnt);
      q.push_back(e);
      step = 1'b1;
      c = 0;
      done = 1'b0;
      while (!done && c < 80) begin
        @(negedge clk);
        c++;
        if (c >= hold) step = 1'b0;
        if ((parado || ilegal) && c >= hold) done = 1'b1;
      end
      check("instr_completes", int'(done), 1);
      if (e.trap) begin
        check("trap_ilegal", int'(ilegal), 1);
        check("trap_no_pc_we", int'(pc_we), 0);
        reset = 1'b0;
        #1;
        check("trap_reset_estado", int'(estado), 0);
        check("trap_reset_ilegal", int'(ilegal), 0);
        model_cnt = 0;
        @(negedge clk); reset = 1'b1;
      end else begin
        model_cnt = (model_cnt + 1) % (1 << LC);
        check("step_single_retire", int'(instr_count), model_cnt);
        check("step_parado", int'(parado), 1);
      end
    end
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("final_count", int'(instr_count), model_cnt);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sequenciador_execucao.md
# sequenciador_execucao

Multi-cycle sequencer for the RV32 datapath. It replaces free-running single-cycle stepping with an explicit fetch/decode/execute/memory/writeback state machine. It drives the PC, instruction-register, register-bank and data-memory enables, supports run, single-step and halt, waits on a data memory with variable read latency, and traps illegal opcodes. It sits between `unidade_de_controle` (which still decodes the instruction fields) and the state elements `gerencia_PC`, `banco_de_registradores` and the data memory.

## Interface
Parameters:
- MAX_ESPERA, 15: maximum consecutive MEM cycles a load may wait for `mem_pronto` before trapping (range 1..255).
- LARG_CONT, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-running execution.
- step  in  1  level; each 0->1 transition, seen while stopped, executes one instruction.
- halt_req  in  1  level; stop after the current instruction retires.
- opcode  in  7  inst[6:0] of the current instruction register.
- regWrite_uc  in  1  register write request from `unidade_de_controle`.
- MemWrite_uc  in  1  store request from `unidade_de_controle`.
- mem_pronto  in  1  data memory read data valid.
- ir_we  out  1  instruction register load enable.
- pc_we  out  1  PC update enable (`novoPC` -> `atualPC`).
- reg_we  out  1  register bank write enable.
- mem_we  out  1  data memory write enable.
- mem_re  out  1  data memory read request.
- estado  out  3  current state encoding.
- parado  out  1  1 while in PARADO.
- ilegal  out  1  1 while in ERRO (sticky until reset).
- instr_count  out  LARG_CONT  retired instructions, wraps modulo 2^LARG_CONT.

## Operation
- State encodings: PARADO=0, BUSCA=1, DECOD=2, EXEC=3, MEM=4, ESCR=5, ERRO=6. Encoding 7 is unreachable and must go to PARADO on the next edge.
- Outputs are decoded from the registered state (Moore), except that reg_we and mem_we are also gated by the *_uc inputs.
- Step edge detection: `step_q` is registered every cycle; the edge is `step & ~step_q`. `step_q` resets to 0.
- State transitions:
  - PARADO: parado=1. Go to BUSCA if the step edge fires, or if run=1 and halt_req=0. Otherwise stay.
  - BUSCA: ir_we=1 for exactly one cycle. Then DECOD.
  - DECOD: legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111 and 0110111. Any other opcode goes to ERRO; a legal one goes to EXEC.
  - EXEC: opcode 0000011 (load) or 0100011 (store) goes to MEM; everything else goes to ESCR.
  - MEM, store: mem_we=MemWrite_uc for one cycle, then ESCR.
  - MEM, load: mem_re=1 every MEM cycle. Wait counter `espera` is cleared on MEM entry and incremented on each MEM cycle with mem_pronto=0. If mem_pronto=1, go to ESCR. Else, if this is the MAX_ESPERA-th consecutive low cycle, go to ERRO. Else stay in MEM.
  - ESCR: reg_we=regWrite_uc, pc_we=1, and instr_count increments by 1 at the edge leaving ESCR. Go to PARADO if halt_req=1 or run=0 (step mode); otherwise go to BUSCA.
  - ERRO: all enables are 0 and ilegal=1. Only reset exits.
- Simultaneous step edge and run=1 in PARADO: one transition to BUSCA, with no double count.
- Step edges outside PARADO are ignored and not queued.
- mem_pronto outside a load MEM cycle is ignored.

## Timing
- Reset (asynchronous assertion, reset=0): estado=PARADO, parado=1, all enables 0, ilegal=0, instr_count=0, espera=0, step_q=0.
- Reset asserted mid-instruction: immediate return to PARADO; no pc_we or reg_we pulse is issued.
- Reset release is synchronous-safe: the first transition can occur on the first rising edge after release.
- Latency per instruction, BUSCA through ESCR inclusive:
  - ALU, branch, jump, lui: 4 cycles.
  - Store: 5 cycles.
  - Load: 5 + (number of MEM cycles with mem_pronto=0) cycles.
- pc_we, reg_we and ir_we are each high for at most one cycle per instruction.
- mem_re is high continuously through a load's MEM wait.

## Test plan
- Reset with run=1 and an R-type stream: after release, estado cycles 1,2,3,5,1,...; pc_we pulses every 4 cycles; instr_count reaches 3 after 12 cycles.
- Single step with run=0: one step pulse gives exactly one BUSCA..ESCR pass, instr_count goes 0->1, and the block returns to PARADO. Holding step high for 20 cycles still retires only 1 instruction.
- Load with mem_pronto rising on the 3rd MEM cycle: mem_re is high for 3 cycles and reg_we=1 in the following cycle. Total latency is 7 cycles.
- Load with mem_pronto stuck low, MAX_ESPERA=15: after 15 MEM cycles estado=6 and ilegal=1; no further pc_we. Asserting reset gives estado=0 and ilegal=0.
- Opcode 0000000 in DECOD: next estado=6; no reg_we, mem_we or pc_we pulse occurs.
- halt_req asserted during EXEC of a store, run=1: mem_we=1 for one cycle, then ESCR, then PARADO; parado=1 and instr_count increments by exactly 1.
